// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback port arbiter.
// The ACC_HAZARD_EN macro enables the decode hazard check in the arbiter and FIFO.
package wb_arb_pkg;
  localparam int ARB_XLEN   = 32;
  localparam int ARB_REG_AW = 5;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ARB_REG_AW-1:0] rd;
    logic [ARB_XLEN-1:0]   data;
  } wr_req_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO for accelerator write results with full/empty/count.
// With ACC_HAZARD_EN defined, it also exposes its storage and per-slot valid mask for hazard compares.
module wb_result_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef ACC_HAZARD_EN
  ,
  output logic [DEPTH-1:0][W-1:0]  mem_o,
  output logic [DEPTH-1:0]         vld_o
`endif
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full    = cnt_q == (PW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

`ifdef ACC_HAZARD_EN
  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] off;
    assign off      = PW'(g) - rd_ptr_q;
    assign vld_o[g] = {1'b0, off} < cnt_q;
    assign mem_o[g] = mem_q[g];
  end
`endif
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the pipeline WB stage and buffered accelerator results.
// Optional ACC_HAZARD_EN adds dec_rs1/dec_rs2 inputs and a combinational hazard_o output.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN       = ARB_XLEN,
  parameter int REG_AW     = ARB_REG_AW,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [REG_AW-1:0] acc_rd,
  input  logic [XLEN-1:0]   acc_data,
  output logic              stall_o,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fifo_empty
`ifdef ACC_HAZARD_EN
  ,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  output logic              hazard_o
`endif
);
  localparam int W  = REG_AW + XLEN;
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } req_t;

  arb_state_e           state_q, state_d;
  logic [CW-1:0]        starve_q, starve_d;
  logic                 rf_we_q, rf_we_d;
  logic [REG_AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
  logic                 full, empty, push, pop, pipe_win, has_entry;
  logic [$clog2(DEPTH):0] occ;
  logic [W-1:0]         head_bits;
  req_t                 head;

  assign acc_ready  = rst_n && !full;
  assign stall_o    = rst_n && (state_q == STALL);
  assign fifo_empty = empty;
  assign push       = acc_valid && acc_ready && (acc_rd != '0);
  assign pipe_win   = wb_valid && (wb_rd != '0);
  assign has_entry  = occ != '0;
  assign head       = req_t'(head_bits);
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

`ifdef ACC_HAZARD_EN
  logic [DEPTH-1:0][W-1:0] mem;
  logic [DEPTH-1:0]        vld;
`endif

  wb_result_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({acc_rd, acc_data}),
    .rdata (head_bits),
    .full  (full),
    .empty (empty),
    .count (occ)
`ifdef ACC_HAZARD_EN
    ,
    .mem_o (mem),
    .vld_o (vld)
`endif
  );

  // Starvation counter clears by default; only a pipeline win over a non-empty FIFO advances it.
  always_comb begin
    state_d    = NORMAL;
    starve_d   = '0;
    pop        = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (state_q == STALL) begin
      pop = has_entry;
    end else if (pipe_win) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
      if (has_entry) begin
        if (starve_q == CW'(STARVE_MAX - 1)) state_d  = STALL;
        else                                  starve_d = starve_q + CW'(1);
      end
    end else begin
      pop = has_entry;
    end
    if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

`ifdef ACC_HAZARD_EN
  always_comb begin
    hazard_o = push && ((acc_rd == dec_rs1) || (acc_rd == dec_rs2));
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem[i][XLEN +: REG_AW] != '0) &&
          ((mem[i][XLEN +: REG_AW] == dec_rs1) || (mem[i][XLEN +: REG_AW] == dec_rs2)))
        hazard_o = 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; hazard scenario runs when ACC_HAZARD_EN is defined.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        acc_valid;
  logic        acc_ready;
  logic [4:0]  acc_rd;
  logic [31:0] acc_data;
  logic        stall_o;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fifo_empty;
`ifdef ACC_HAZARD_EN
  logic [4:0]  dec_rs1, dec_rs2;
  logic        hazard_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_rd     (acc_rd),
    .acc_data   (acc_data),
    .stall_o    (stall_o),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fifo_empty (fifo_empty)
`ifdef ACC_HAZARD_EN
    ,
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .hazard_o   (hazard_o)
`endif
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    acc_valid = 1'b1; acc_rd = 5'd5; acc_data = 32'h1;
`ifdef ACC_HAZARD_EN
    dec_rs1 = '0; dec_rs2 = '0;
`endif
    repeat (3) nxt();
    checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL rst_acc_ready got=%b exp=0", acc_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got=%b exp=0", rf_we); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    rst_n = 1'b1; acc_valid = 1'b0;
    #1;
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL rel_acc_ready got=%b exp=1", acc_ready); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rel_fifo_empty got=%b exp=1", fifo_empty); end
    nxt();
  endtask

  task automatic test_idle_fifo();
    acc_valid = 1'b1; acc_rd = 5'd5; acc_data = 32'hDEADBEEF; #1;
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", acc_ready); end
    nxt();
    acc_valid = 1'b0; #1;
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL idle_nonempty got=%b exp=0", fifo_empty); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we_early got=%b exp=0", rf_we); end
    nxt();
    #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
      begin errors++; $display("FAIL idle_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL idle_drained got=%b exp=1", fifo_empty); end
    nxt();
  endtask

  task automatic test_priority();
    int stalls = 0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    acc_valid = 1'b1; acc_rd = 5'd10; acc_data = 32'hA5;
    #1; nxt();
    acc_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (stall_o === 1'b1) stalls++;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL prio_nostall cyc=%0d got=%b exp=0", k, stall_o); end
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11})
        begin errors++; $display("FAIL prio_pipe cyc=%0d got=%b/%0d/%h exp=1/3/11", k, rf_we, rf_waddr, rf_wdata); end
      nxt();
    end
    #1;
    if (stall_o === 1'b1) stalls++;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL prio_stall got=%b exp=1", stall_o); end
    checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL prio_last_pipe got=%b/%0d exp=1/3", rf_we, rf_waddr); end
    nxt();
    #1;
    if (stall_o === 1'b1) stalls++;
    checks++; if (stalls != 1) begin errors++; $display("FAIL prio_stall_count got=%0d exp=1", stalls); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'hA5})
      begin errors++; $display("FAIL prio_acc_write got=%b/%0d/%h exp=1/10/a5", rf_we, rf_waddr, rf_wdata); end
    nxt();
    wb_valid = 1'b0; #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11})
      begin errors++; $display("FAIL prio_replay got=%b/%0d/%h exp=1/3/11", rf_we, rf_waddr, rf_wdata); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL prio_empty got=%b exp=1", fifo_empty); end
    nxt();
  endtask

  task automatic test_full_fifo();
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      acc_valid = 1'b1; acc_rd = 5'(11 + i); acc_data = 32'(32'h100 + 11 + i); #1;
      checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d got=%b exp=1", i, acc_ready); end
      nxt();
    end
    acc_rd = 5'd15; acc_data = 32'h10F;
    for (int q = 4; q <= 9; q++) begin
      #1;
      checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL full_blocked q=%0d got=%b exp=0", q, acc_ready); end
      checks++; if (stall_o !== (q == 9)) begin errors++; $display("FAIL full_stall q=%0d got=%b exp=%b", q, stall_o, q == 9); end
      nxt();
    end
    #1;
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL full_reopen got=%b exp=1", acc_ready); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd11, 32'h10B})
      begin errors++; $display("FAIL full_first_pop got=%b/%0d/%h exp=1/11/10b", rf_we, rf_waddr, rf_wdata); end
    nxt();
    acc_valid = 1'b0; wb_valid = 1'b0; #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h22})
      begin errors++; $display("FAIL full_pipe got=%b/%0d/%h exp=1/4/22", rf_we, rf_waddr, rf_wdata); end
    nxt();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(12 + i), 32'(32'h100 + 12 + i)})
        begin errors++; $display("FAIL full_drain%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 12 + i, 32'h100 + 12 + i); end
      nxt();
    end
    #1;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%b exp=1", fifo_empty); end
    nxt();
  endtask

  task automatic test_x0_filter();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h33;
    acc_valid = 1'b1; acc_rd = 5'd7; acc_data = 32'h77;
    #1; nxt();
    acc_valid = 1'b0; #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_nowrite got=%b exp=0", rf_we); end
    nxt();
    #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h77})
      begin errors++; $display("FAIL x0_acc_write got=%b/%0d/%h exp=1/7/77", rf_we, rf_waddr, rf_wdata); end
    nxt();
    acc_valid = 1'b1; acc_rd = 5'd0; acc_data = 32'h99; #1;
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL x0_push_ready got=%b exp=1", acc_ready); end
    nxt();
    acc_valid = 1'b0; #1;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL x0_push_dropped got=%b exp=1", fifo_empty); end
    nxt();
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_no_acc_write got=%b exp=0", rf_we); end
    wb_valid = 1'b0;
    nxt();
  endtask

`ifdef ACC_HAZARD_EN
  task automatic test_hazard();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h44;
    acc_valid = 1'b1; acc_rd = 5'd9; acc_data = 32'h9;
    dec_rs1 = 5'd0; dec_rs2 = 5'd9; #1;
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL haz_inflight got=%b exp=1", hazard_o); end
    nxt();
    acc_valid = 1'b0; #1;
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL haz_stored got=%b exp=1", hazard_o); end
    dec_rs2 = 5'd4; #1;
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL haz_nomatch got=%b exp=0", hazard_o); end
    dec_rs2 = 5'd0; #1;
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL haz_zero got=%b exp=0", hazard_o); end
    dec_rs1 = 5'd9; #1;
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL haz_rs1 got=%b exp=1", hazard_o); end
    dec_rs1 = 5'd0; dec_rs2 = 5'd9; wb_valid = 1'b0;
    nxt();
    #1;
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL haz_after_pop got=%b exp=0", hazard_o); end
    checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd9}) begin errors++; $display("FAIL haz_pop_write got=%b/%0d exp=1/9", rf_we, rf_waddr); end
    dec_rs2 = 5'd0;
    nxt();
  endtask
`endif

  initial begin
    test_reset();
    test_idle_fifo();
    test_priority();
    test_full_fifo();
    test_x0_filter();
`ifdef ACC_HAZARD_EN
    test_hazard();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
